// File: rtl/uart_tx.sv
// uart_tx: UART transmitter (8N1) with a 32-entry register-based write FIFO.
// The FIFO pushes bytes on fifo_tx_wr_en_p. The engine pops each byte and
// shifts it out LSB-first on tx_p, timed by the shared 16x baud strobe.
// Optional feature: define UART_TX_PARITY_EN to add a parity bit between the
// data and stop bits. Its sense is selected by parity_odd_p.
module uart_tx #(
   parameter int FIFO_AW       = 5,
   parameter int TICKS_PER_BIT = 16
) (
   input  logic               clk210_p,
   input  logic               reset_p,
   input  logic               baud_16_x_p,
   input  logic [7:0]         fifo_tx_din_p,
   input  logic               fifo_tx_wr_en_p,
`ifdef UART_TX_PARITY_EN
   input  logic               parity_odd_p,
`endif
   output logic               fifo_tx_full_p,
   output logic               fifo_tx_empty_p,
   output logic [FIFO_AW:0]   fifo_tx_data_count_p,
   output logic               fifo_tx_overflow_p,
   output logic               tx_busy_p,
   output logic               tx_done_p,
   output logic               tx_p
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int TW    = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam logic [FIFO_AW:0] DEPTH_C    = (FIFO_AW+1)'(DEPTH);
   localparam logic [TW-1:0]    TICK_LAST  = TW'(TICKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_PARITY = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
   } state_t;
`endif

   // ---------------------------------------------------------------- FIFO
   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               overflow_q;
   logic               full, empty, wr_accept, pop;
   logic [7:0]         head;

   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign wr_accept = fifo_tx_wr_en_p & ~full;
   assign head      = mem_q[rd_ptr_q];

   // Storage array: written on accepted pushes and never reset, because only the pointers matter.
   always_ff @(posedge clk210_p) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q] <= fifo_tx_din_p;
      end
   end

   // Pointer, occupancy and sticky overflow bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_accept, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (fifo_tx_wr_en_p && full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------ transmit engine
   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          bit_end;
   logic          load_par;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
   assign load_par = (^head) ^ parity_odd_p;
`else
   assign load_par = 1'b0;
`endif

   // A serial bit ends on the baud tick that completes its last tick count.
   assign bit_end = baud_16_x_p && (tick_q == TICK_LAST);

   // State register.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: bit states advance only at bit boundaries.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!empty) state_d = S_START;
         S_START: if (bit_end) state_d = S_DATA;
         S_DATA: begin
            if (bit_end && bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (bit_end) state_d = S_STOP;
`endif
         S_STOP:  if (bit_end) state_d = empty ? S_IDLE : S_START;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath logic: computes the next line level, so tx_p always comes from a flop.
   always_comb begin
      shift_d = shift_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (state_q != S_IDLE && baud_16_x_p) begin
         tick_d = bit_end ? '0 : tick_q + 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               tick_d  = '0;
`ifdef UART_TX_PARITY_EN
               par_d   = load_par;
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               tx_d  = shift_q[0];
               bit_d = 3'd0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d = par_q;
`else
                  tx_d = 1'b1;
`endif
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               tx_d = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               done_d = 1'b1;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  tick_d  = '0;
`ifdef UART_TX_PARITY_EN
                  par_d   = load_par;
`endif
               end else begin
                  tx_d   = 1'b1;
                  busy_d = 1'b0;
               end
            end
         end
         default: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
      endcase
   end

   // Datapath registers; reset forces the line back to idle-high at once.
   always_ff @(posedge clk210_p or posedge reset_p) begin
      if (reset_p) begin
         shift_q <= '0;
         tick_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         shift_q <= shift_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // The parity bit is unused in the plain 8N1 build.
   logic unused_ok;
   assign unused_ok = load_par;

   assign fifo_tx_full_p       = full;
   assign fifo_tx_empty_p      = empty;
   assign fifo_tx_data_count_p = count_q;
   assign fifo_tx_overflow_p   = overflow_q;
   assign tx_busy_p            = busy_q;
   assign tx_done_p            = done_q;
   assign tx_p                 = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud;
   logic [7:0] din;
   logic       wr_en;
   logic       full, empty, overflow, busy, done, tx;
   logic [5:0] count;
`ifdef UART_TX_PARITY_EN
   logic       par_odd;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int div     = 0;
   int ecount  = 0;
   logic [7:0] rx_b;

   always #5 clk = ~clk;

   uart_tx dut (
      .clk210_p             (clk),
      .reset_p              (rst),
      .baud_16_x_p          (baud),
      .fifo_tx_din_p        (din),
      .fifo_tx_wr_en_p      (wr_en),
`ifdef UART_TX_PARITY_EN
      .parity_odd_p         (par_odd),
`endif
      .fifo_tx_full_p       (full),
      .fifo_tx_empty_p      (empty),
      .fifo_tx_data_count_p (count),
      .fifo_tx_overflow_p   (overflow),
      .tx_busy_p            (busy),
      .tx_done_p            (done),
      .tx_p                 (tx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: choose the baud strobe for the coming edge, then sample 1 ns after it.
   task automatic step();
      if (div > 0) baud = ((ecount % div) == 0);
      else         baud = 1'b0;
      ecount++;
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      din   = b;
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
   endtask

   // Check the line level on every cycle of a frame that starts at the current sample.
   task automatic check_frame(input logic [7:0] b, input int cpb, input int nbits,
                              input logic pbit, input string tag);
      logic [10:0] bits;
      bits[0]   = 1'b0;
      bits[8:1] = b;
      bits[9]   = (nbits == 11) ? pbit : 1'b1;
      bits[10]  = 1'b1;
      for (int k = 0; k < nbits * cpb; k++) begin
         check({tag, "_tx"}, tx, bits[k / cpb]);
         check({tag, "_busy"}, busy, 1);
         if (k > 0) check({tag, "_done"}, done, 0);
         step();
      end
      $display("[TB] frame %s 0x%02h checked over %0d cycles", tag, b, nbits * cpb);
   endtask

   // Receive one frame with a tick every cycle; skip moves from the current start-bit phase to mid-bit.
   task automatic recv(input int skip, output logic [7:0] b);
      int guard = 0;
      while (tx !== 1'b0 && guard < 2000) begin
         step();
         guard++;
      end
      if (guard >= 2000) check("recv_timeout", 1, 0);
      repeat (skip) step();
      check("recv_start", tx, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (16) step();
         b[i] = tx;
      end
      repeat (16) step();
      check("recv_stop", tx, 1);
      $display("[TB] received 0x%02h", b);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      baud  = 1'b0;
      din   = 8'h00;
      wr_en = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_odd = 1'b0;
`endif
      repeat (3) step();
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;
      step();
      $display("[TB] reset values checked");

      // 0x55 with the tick tied high.
      div = 1; ecount = 0;
      write_byte(8'h55);
      check("w55_count", count, 1);
      check("w55_empty", empty, 0);
      check("w55_tx_idle", tx, 1);
      step();
      check("pop55_count", count, 0);
      check_frame(8'h55, 16, 10, 1'b0, "f55");
      check("f55_done_pulse", done, 1);
      check("f55_busy_fall", busy, 0);
      check("f55_tx_idle", tx, 1);
      step();
      check("f55_done_clear", done, 0);

      // 0xA3 then 0x0F, tick every 4th cycle; the tick lands on the pop edge.
      div = 4; ecount = -1;
      write_byte(8'hA3);
      check("wa3_count", count, 1);
      write_byte(8'h0F);
      check("w0f_count", count, 1);
      check_frame(8'hA3, 64, 10, 1'b0, "fa3");
      check("fa3_done", done, 1);
      check("fa3_count", count, 0);
      check_frame(8'h0F, 64, 10, 1'b0, "f0f");
      check("f0f_done", done, 1);
      check("f0f_busy_fall", busy, 0);
      step();

      // Fill with no ticks: one byte parked in the engine, then 33 pushes.
      div = 0;
      write_byte(8'hC0);
      step();
      check("park_busy", busy, 1);
      check("park_count", count, 0);
      for (int i = 0; i < 33; i++) begin
         write_byte(8'(8'h20 + i));
         $display("[TB] push 0x%02h count=%0d full=%0d ovf=%0d", 8'(8'h20 + i), count, full, overflow);
         if (i == 30) check("fill_notfull31", full, 0);
         if (i == 31) begin
            check("fill_full32", full, 1);
            check("fill_count32", count, 32);
            check("fill_noovf32", overflow, 0);
         end
         if (i == 32) begin
            check("fill_ovf33", overflow, 1);
            check("fill_count33", count, 32);
         end
      end
      div = 1; ecount = 0;
      step();
      recv(7, rx_b);
      check("drain_c0", rx_b, 8'hC0);
      for (int j = 0; j < 32; j++) begin
         recv(8, rx_b);
         check("drain_byte", rx_b, 32'(8'h20 + j));
      end
      check("drain_last", rx_b, 8'h3F);
      repeat (20) step();
      check("drain_busy", busy, 0);
      check("drain_empty", empty, 1);
      check("drain_ovf_sticky", overflow, 1);

      // Reset in the middle of a 0xFF frame with five bytes queued.
      write_byte(8'hFF);
      for (int i = 0; i < 5; i++) write_byte(8'(8'h60 + i));
      check("mid_count", count, 5);
      repeat (36) step();
      check("mid_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_tx", tx, 1);
      check("arst_busy", busy, 0);
      check("arst_empty", empty, 1);
      check("arst_count", count, 0);
      check("arst_ovf", overflow, 0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 300; k++) begin
         check("post_rst_tx", tx, 1);
         step();
      end
      check("post_rst_busy", busy, 0);
      $display("[TB] reset mid-frame checked");

      // Simultaneous push and pop at count 3.
      div = 0;
      write_byte(8'h81);
      step();
      write_byte(8'h82);
      write_byte(8'h83);
      write_byte(8'h84);
      check("sim_count3", count, 3);
      div = 1; ecount = 0;
      step();
      repeat (158) step();
      din = 8'h85; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      check("sim_count_hold", count, 3);
      check("sim_done", done, 1);
      check("sim_tx_start", tx, 0);
      for (int j = 0; j < 4; j++) begin
         recv(8, rx_b);
         check("sim_order", rx_b, 32'(8'h82 + j));
      end
      repeat (20) step();

`ifdef UART_TX_PARITY_EN
      // 0x07 has three ones: even parity bit 1, odd parity bit 0.
      par_odd = 1'b0;
      write_byte(8'h07);
      step();
      check_frame(8'h07, 16, 11, 1'b1, "fpe");
      check("fpe_done", done, 1);
      step();
      par_odd = 1'b1;
      write_byte(8'h07);
      step();
      check_frame(8'h07, 16, 11, 1'b0, "fpo");
      check("fpo_done", done, 1);
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
